// File: rtl/db_dma_copier_pkg.sv
// Shared DataBus codes and small helpers for the DMA copier.
package db_dma_copier_pkg;

    // Bus request kind; NONE means no request this cycle.
    typedef enum logic [1:0] {
        MEM_ACCESS_NONE = 2'd0,
        MEM_ACCESS_R    = 2'd1,
        MEM_ACCESS_W    = 2'd2
    } mem_access_e;

    // Transfer width: byte, halfword, word.
    typedef enum logic [1:0] {
        MEM_LEN_B = 2'd0,
        MEM_LEN_H = 2'd1,
        MEM_LEN_W = 2'd2
    } mem_len_e;

    // Mask that keeps the right-justified bits of a transfer of the given width.
    function automatic logic [31:0] len_mask(input mem_len_e l);
        logic [31:0] m;
        case (l)
            MEM_LEN_B: m = 32'h0000_00FF;
            MEM_LEN_H: m = 32'h0000_FFFF;
            default:   m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/db_dma_copier_unit_sel.sv
// Picks the widest legal transfer unit from current alignment and bytes left.
module db_dma_unit_sel
    import db_dma_copier_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic [1:0]       sa_lo,
    input  logic [1:0]       da_lo,
    input  logic [LEN_W-1:0] rem,
    output mem_len_e         mem_len,
    output logic [2:0]       n_bytes
);

    // Word needs both addresses word-aligned, halfword needs both even.
    always_comb begin
        mem_len = MEM_LEN_B;
        n_bytes = 3'd1;
        if (sa_lo == 2'b00 && da_lo == 2'b00 && rem >= LEN_W'(4)) begin
            mem_len = MEM_LEN_W;
            n_bytes = 3'd4;
        end else if (!sa_lo[0] && !da_lo[0] && rem >= LEN_W'(2)) begin
            mem_len = MEM_LEN_H;
            n_bytes = 3'd2;
        end
    end

endmodule

// File: rtl/db_dma_copier.sv
// DataBus initiator that copies len bytes from src to dst, one read then one
// write per unit, ascending addresses.
//
// Handshake: a request (db_accessType != NONE) is held with all bus outputs
// stable until a posedge where db_ready=1; that edge is the acceptance. Read
// data arrives on db_dataIn during the cycle after read acceptance.
module db_dma_copier
    import db_dma_copier_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [31:0]      db_addr,
    output logic [31:0]      vAddr,
    output logic [31:0]      db_dataOut,
    output mem_access_e      db_accessType,
    output mem_len_e         db_memLen,
    output logic             db_io,
    input  logic             db_ready,
    input  logic [31:0]      db_dataIn,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      sa_q, sa_d;
    logic [31:0]      da_q, da_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    mem_len_e         unit_q, unit_d;
    logic [2:0]       nb_q, nb_d;
    logic [31:0]      buf_q, buf_d;

    mem_len_e         sel_len;
    logic [2:0]       sel_n;

    db_dma_unit_sel #(.LEN_W(LEN_W)) u_unit_sel (
        .sa_lo   (sa_q[1:0]),
        .da_lo   (da_q[1:0]),
        .rem     (rem_q),
        .mem_len (sel_len),
        .n_bytes (sel_n)
    );

    // State and datapath registers; reset abandons any copy in flight.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            da_q    <= '0;
            rem_q   <= '0;
            unit_q  <= MEM_LEN_B;
            nb_q    <= 3'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            da_q    <= da_d;
            rem_q   <= rem_d;
            unit_q  <= unit_d;
            nb_q    <= nb_d;
            buf_q   <= buf_d;
        end
    end

    // Next state and bus outputs; outputs idle at NONE/0/B outside RD and WR.
    always_comb begin
        state_d       = state_q;
        sa_d          = sa_q;
        da_d          = da_q;
        rem_d         = rem_q;
        unit_d        = unit_q;
        nb_d          = nb_q;
        buf_d         = buf_q;
        busy          = 1'b0;
        done          = 1'b0;
        db_addr       = 32'h0;
        db_dataOut    = 32'h0;
        db_accessType = MEM_ACCESS_NONE;
        db_memLen     = MEM_LEN_B;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        sa_d    = src;
                        da_d    = dst;
                        rem_d   = len;
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD: begin
                busy          = 1'b1;
                db_accessType = MEM_ACCESS_R;
                db_addr       = sa_q;
                db_memLen     = sel_len;
                // Freeze the unit so the write matches the read that was issued.
                if (db_ready) begin
                    unit_d  = sel_len;
                    nb_d    = sel_n;
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                busy    = 1'b1;
                buf_d   = db_dataIn & len_mask(unit_q);
                state_d = ST_WR;
            end
            ST_WR: begin
                busy          = 1'b1;
                db_accessType = MEM_ACCESS_W;
                db_addr       = da_q;
                db_memLen     = unit_q;
                db_dataOut    = buf_q;
                if (db_ready) begin
                    sa_d    = sa_q + 32'(nb_q);
                    da_d    = da_q + 32'(nb_q);
                    rem_d   = rem_q - LEN_W'(nb_q);
                    state_d = (rem_q == LEN_W'(nb_q)) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign vAddr     = db_addr;
    assign db_io     = 1'b0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_db_dma_copier.sv
// Self-checking bench for db_dma_copier: stalling memory responder, trace
// scoreboard built from a byte-level copy model, latency and reset checks.
module tb_db_dma_copier;
    import db_dma_copier_pkg::*;

    localparam int LEN_W = 16;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             res_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      src = 32'h0;
    logic [31:0]      dst = 32'h0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done;
    logic [31:0]      db_addr, vAddr, db_dataOut;
    mem_access_e      db_accessType;
    mem_len_e         db_memLen;
    logic             db_io;
    logic             db_ready = 1'b0;
    logic [31:0]      db_dataIn = 32'h0;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    db_dma_copier #(.LEN_W(LEN_W)) dut (
        .clk           (clk),
        .res_n         (res_n),
        .start         (start),
        .src           (src),
        .dst           (dst),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .db_addr       (db_addr),
        .vAddr         (vAddr),
        .db_dataOut    (db_dataOut),
        .db_accessType (db_accessType),
        .db_memLen     (db_memLen),
        .db_io         (db_io),
        .db_ready      (db_ready),
        .db_dataIn     (db_dataIn),
        .dbg_state     (dbg_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- memory model (4 KiB, big-endian) ----------------
    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [67:0] exp_q[$];   // {access, len, addr, data}

    function automatic logic [31:0] rd_mem(input logic [31:0] a, input int nb);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < nb; k++) v = {v[23:0], mem[12'(a + 32'(k))]};
        return v;
    endfunction

    function automatic int len_bytes(input mem_len_e l);
        return (l == MEM_LEN_W) ? 4 : (l == MEM_LEN_H) ? 2 : 1;
    endfunction

    // ---------------- stalling responder ----------------
    int          wait_cnt = 0;
    int          cur_stall = 0;
    int          stall_max = 0;
    int          stall_total = 0;
    bit          stall_rand = 1'b0;
    bit          rd_pend = 1'b0;
    logic [31:0] pend_val = 32'h0;
    logic [67:0] snap = '0;

    // Decide ready away from the active edge; a granted request is accepted at the next posedge.
    always @(negedge clk) begin
        logic [67:0] obs;
        logic [67:0] e;
        int          nb;
        obs = {db_accessType, db_memLen, db_addr,
               (db_accessType == MEM_ACCESS_W) ? db_dataOut : 32'h0};
        if (!res_n || db_accessType == MEM_ACCESS_NONE) begin
            db_ready = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt < cur_stall) begin
            if (wait_cnt > 0) check_eq("hold", {db_accessType, db_memLen, db_addr, db_dataOut}, snap);
            snap = {db_accessType, db_memLen, db_addr, db_dataOut};
            db_ready = 1'b0;
            wait_cnt++;
            stall_total++;
        end else begin
            if (wait_cnt > 0) check_eq("hold", {db_accessType, db_memLen, db_addr, db_dataOut}, snap);
            db_ready = 1'b1;
            if (exp_q.size() == 0) begin
                check_eq("extra_req", obs, 68'h0);
            end else begin
                e = exp_q.pop_front();
                check_eq("bus", obs, e);
                check_eq("vaddr", 68'(vAddr), 68'(e[63:32]));
            end
            nb = len_bytes(db_memLen);
            if (db_accessType == MEM_ACCESS_R) begin
                pend_val = rd_mem(db_addr, nb);
                rd_pend  = 1'b1;
            end else begin
                for (int k = 0; k < nb; k++)
                    mem[12'(db_addr + 32'(k))] = 8'(db_dataOut >> (8 * (nb - 1 - k)));
            end
            wait_cnt  = 0;
            cur_stall = stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
        end
    end

    // Read data is valid only in the cycle after acceptance; garbage otherwise.
    always @(posedge clk) begin
        if (rd_pend) begin
            db_dataIn <= pend_val;
            rd_pend = 1'b0;
        end else begin
            db_dataIn <= $urandom();
        end
    end

    // ---------------- reference model ----------------
    // Plain byte-level copy: widest legal unit each step, ascending, mod 2^32.
    task automatic build_model(input logic [31:0] s, input logic [31:0] d,
                               input int l, output int units);
        logic [31:0] sa, da, v;
        int          rem, nb;
        mem_len_e    lc;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        sa = s; da = d; rem = l; units = 0;
        while (rem > 0) begin
            if (sa % 4 == 0 && da % 4 == 0 && rem >= 4)      nb = 4;
            else if (sa % 2 == 0 && da % 2 == 0 && rem >= 2) nb = 2;
            else                                              nb = 1;
            lc = (nb == 4) ? MEM_LEN_W : (nb == 2) ? MEM_LEN_H : MEM_LEN_B;
            v = 32'h0;
            for (int k = 0; k < nb; k++) v = (v << 8) | 32'(ref_mem[12'(sa + 32'(k))]);
            for (int k = 0; k < nb; k++) ref_mem[12'(da + 32'(k))] = 8'(v >> (8 * (nb - 1 - k)));
            exp_q.push_back({MEM_ACCESS_R, lc, sa, 32'h0});
            exp_q.push_back({MEM_ACCESS_W, lc, da, v});
            sa = sa + 32'(nb);
            da = da + 32'(nb);
            rem = rem - nb;
            units++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"}, 68'(busy), 68'(0));
        check_eq({tag, "_done"}, 68'(done), 68'(0));
        check_eq({tag, "_acc"},  68'(db_accessType), 68'(MEM_ACCESS_NONE));
        check_eq({tag, "_addr"}, 68'(db_addr), 68'(0));
        check_eq({tag, "_vaddr"}, 68'(vAddr), 68'(0));
        check_eq({tag, "_dout"}, 68'(db_dataOut), 68'(0));
        check_eq({tag, "_mlen"}, 68'(db_memLen), 68'(MEM_LEN_B));
        check_eq({tag, "_io"},   68'(db_io), 68'(0));
    endtask

    task automatic check_mem(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) errs++;
        check_eq(tag, 68'(errs), 68'(0));
    endtask

    // ---------------- driver ----------------
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l,
                            input int smax, input bit srand, input bit poke);
        int units, cyc, exp_cyc;
        bit got;
        build_model(s, d, l, units);
        stall_max   = smax;
        stall_rand  = srand;
        cur_stall   = srand ? int'($urandom_range(0, smax)) : smax;
        stall_total = 0;
        @(negedge clk);
        src = s; dst = d; len = LEN_W'(l); start = 1'b1;
        cyc = 0; got = 1'b0;
        while (cyc < 2000 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                src = $urandom(); dst = $urandom(); len = LEN_W'($urandom());
                if (l != 0) check_eq("busy_start", 68'(busy), 68'(1));
            end
            if (poke && cyc == 2) begin
                start = 1'b1; src = 32'h0; dst = 32'h0;
                len = LEN_W'($urandom_range(1, 20));
            end
            if (poke && cyc == 3) start = 1'b0;
            if (done) got = 1'b1;
        end
        check_eq("done_seen", 68'(got), 68'(1));
        exp_cyc = 3 * units + 1 + (srand ? stall_total : 2 * units * smax);
        check_eq("latency", 68'(cyc), 68'(exp_cyc));
        check_eq("busy_done", 68'(busy), 68'(0));
        check_eq("acc_done", 68'(db_accessType), 68'(MEM_ACCESS_NONE));
        if (poke) begin
            start = 1'b1; src = 32'h10; dst = 32'h20; len = LEN_W'(5);
        end
        @(negedge clk);
        start = 1'b0;
        check_eq("done_pulse", 68'(done), 68'(0));
        if (poke) begin
            @(negedge clk);
            check_eq("start_in_done", 68'(busy), 68'(0));
        end
        check_eq("trace_left", 68'(exp_q.size()), 68'(0));
        exp_q.delete();
        check_mem("mem");
    endtask

    task automatic reset_mid_copy();
        int units, ndone;
        bit trig;
        build_model(32'h100, 32'h380, 8, units);
        stall_max = 1; stall_rand = 1'b0; cur_stall = 1;
        @(negedge clk);
        src = 32'h100; dst = 32'h380; len = LEN_W'(8); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        trig = 1'b0;
        for (int i = 0; i < 200 && !trig; i++) begin
            @(posedge clk);
            #1;
            if (db_accessType == MEM_ACCESS_W && db_addr == 32'h384) trig = 1'b1;
        end
        check_eq("rst_trig", 68'(trig), 68'(1));
        res_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        exp_q.delete();
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("rst_no_done", 68'(ndone), 68'(0));
        res_n = 1'b1;
        @(negedge clk);
        run_copy(32'h100, 32'h380, 8, 0, 1'b0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] s, d;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom());
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 8'(8'h11 * (i + 1));
        res_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        res_n = 1'b1;
        @(negedge clk);

        run_copy(32'h100, 32'h200, 8, 0, 1'b0, 1'b0);   // W,W
        run_copy(32'h101, 32'h205, 3, 0, 1'b0, 1'b0);   // B,H
        run_copy(32'h000, 32'h040, 7, 0, 1'b0, 1'b0);   // W,H,B
        run_copy(32'h120, 32'h220, 4, 3, 1'b0, 1'b0);   // 3-cycle stall per request
        run_copy(32'h130, 32'h230, 0, 0, 1'b0, 1'b0);   // zero length
        run_copy(32'h140, 32'h240, 12, 1, 1'b0, 1'b1);  // start while busy / in done
        reset_mid_copy();
        run_copy(32'hFFFF_FFFE, 32'h600, 6, 1, 1'b1, 1'b0);  // source wraps past 2^32

        repeat (25) begin
            s = 32'($urandom_range(0, 2047));
            d = 32'($urandom_range(2048, 4000));
            run_copy(s, d, $urandom_range(0, 24), $urandom_range(0, 2), 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
